// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use / mult-div stall, wrong-path flush, ID operand forwarding
// and latency sequencing of the shared iterative mult/div unit.
module pipe_hazard_ctrl #(
    parameter int MD_LAT = 32
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_is_md,
    input  logic       id_rd_hilo,
    input  logic       id_branch_taken,
    input  logic       exe_wreg,
    input  logic       exe_m2reg,
    input  logic [4:0] exe_rn,
    input  logic       mem_wreg,
    input  logic       mem_m2reg,
    input  logic [4:0] mem_rn,
    output logic       stall,
    output logic       bubble,
    output logic       flush,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       md_start,
    output logic       md_busy,
    output logic       md_done
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t     state;
    logic [7:0] cnt;
    logic       lu, mdh;

    // A load in EXE is not forwardable; it falls through to the MEM check and stalls instead.
    function automatic logic [1:0] fwd_sel(input logic use_src, input logic [4:0] src);
        return (!use_src || src == 5'd0) ? 2'd0 :
               (exe_wreg && !exe_m2reg && exe_rn == src) ? 2'd1 :
               (mem_wreg && mem_rn == src) ? (mem_m2reg ? 2'd3 : 2'd2) : 2'd0;
    endfunction

    always_comb begin
        fwd_a    = fwd_sel(id_use_rs, id_rs);
        fwd_b    = fwd_sel(id_use_rt, id_rt);
        lu       = exe_wreg && exe_m2reg &&
                   ((id_use_rs && id_rs != 5'd0 && exe_rn == id_rs) ||
                    (id_use_rt && id_rt != 5'd0 && exe_rn == id_rt));
        mdh      = md_busy && (id_is_md || id_rd_hilo);
        stall    = lu || mdh;
        bubble   = stall;
        flush    = id_branch_taken && !stall;
        md_start = (state == IDLE) && id_is_md && !stall;
    end

    // cnt counts down to 1; md_done is registered so it lands in the first IDLE cycle.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            md_busy <= 1'b0;
            md_done <= 1'b0;
        end else begin
            md_done <= 1'b0;
            if (state == IDLE) begin
                if (md_start) begin
                    state   <= RUN;
                    cnt     <= 8'(MD_LAT - 1);
                    md_busy <= 1'b1;
                end
            end else begin
                cnt <= cnt - 8'd1;
                if (cnt == 8'd1) begin
                    state   <= IDLE;
                    md_busy <= 1'b0;
                    md_done <= 1'b1;
                end
            end
        end
    end
endmodule
